// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX among NUM_REQ byte requesters:
// grants one frame at a time, strobes it out, tracks busy and spaces frames.
module uart_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int FRAME_WIDTH   = 8,
    parameter int ID_WIDTH      = 2,
    parameter int GAP_CYCLES    = 0,
    parameter int START_TIMEOUT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_busy,
    output logic                           tx_data_valid,
    output logic [FRAME_WIDTH-1:0]         tx_p_data,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           sched_busy,
    output logic                           err_no_start
);

    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(START_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    // IDLE arbitrate | ISSUE strobe byte | WAIT_BUSY await busy or timeout | WAIT_DONE await frame end | GAP spacing
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    last_grant_q;
    logic [ID_WIDTH-1:0]    grant_id_q;
    logic [FRAME_WIDTH-1:0] data_q;
    logic                   data_valid_q;
    logic                   sched_busy_q;
    logic                   err_q;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

    logic                   found;
    logic [ID_WIDTH-1:0]    winner;
    logic [NUM_REQ-1:0]     winner_oh;
    logic [NUM_REQ-1:0]     cand;
    int                     idx;
    logic [FRAME_WIDTH-1:0] win_data;
    logic                   grant;
    logic                   timeout;

    always_comb begin
        found     = 1'b0;
        winner    = '0;
        winner_oh = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last_grant_q) + k) % NUM_REQ;
            cand = NUM_REQ'(1) << idx;
            if (!found && ((req_valid & cand) != '0)) begin
                found     = 1'b1;
                winner    = ID_WIDTH'(idx);
                winner_oh = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_oh[i]) begin
                win_data = req_data[i*FRAME_WIDTH +: FRAME_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        grant     = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tx_busy && found) begin
                    grant   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_LIMIT) begin
                        timeout   = 1'b1;
                        gap_cnt_d = GAP_LOAD;
                        state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                // leave on the count of 1 so exactly GAP_CYCLES cycles are spent here
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            grant_id_q   <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            sched_busy_q <= 1'b0;
            err_q        <= 1'b0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            data_valid_q <= (state_d == S_ISSUE);
            sched_busy_q <= (state_d != S_IDLE);
            err_q        <= timeout;
            if (grant) begin
                last_grant_q <= winner;
                grant_id_q   <= winner;
                data_q       <= win_data;
            end
        end
    end

    assign req_ready     = grant ? winner_oh : '0;
    assign tx_data_valid = data_valid_q;
    assign tx_p_data     = data_q;
    assign grant_id      = grant_id_q;
    assign sched_busy    = sched_busy_q;
    assign err_no_start  = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a timestamp-based reference model.
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int FW  = 8;
    localparam int IDW = 2;
    localparam int GAP = 3;
    localparam int TO  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR*FW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             tx_busy;
    logic             tx_data_valid;
    logic [FW-1:0]    tx_p_data;
    logic [IDW-1:0]   grant_id;
    logic             sched_busy;
    logic             err_no_start;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ      (NR),
        .FRAME_WIDTH  (FW),
        .ID_WIDTH     (IDW),
        .GAP_CYCLES   (GAP),
        .START_TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_busy      (tx_busy),
        .tx_data_valid(tx_data_valid),
        .tx_p_data    (tx_p_data),
        .grant_id     (grant_id),
        .sched_busy   (sched_busy),
        .err_no_start (err_no_start)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    bit            rst_req;
    logic [NR-1:0] pend;
    logic [NR-1:0] rearm;
    logic [FW-1:0] rdat [NR];

    int u_start = -1;
    int u_end   = -1;
    int u_delay = 1;
    int u_len   = 11;
    bit u_nostart  = 0;
    bit force_busy = 0;

    // reference model: frame timeline expressed as cycle stamps
    bit            m_active;
    bit            m_busy_seen;
    int            m_issue_at, m_idle_at, m_err_at, m_last, m_gid;
    logic [FW-1:0] m_byte;

    int   strobe_cyc[$];
    int   strobe_id[$];
    int   strobe_dat[$];
    int   err_cyc[$];
    int   fall_cyc  = -1;
    logic prev_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic drive();
        @(posedge clk);
        #1;
        cyc++;
        reset = rst_req;
        for (int i = 0; i < NR; i++) begin
            if (!pend[i]) rdat[i] = FW'($urandom);
            req_data[i*FW +: FW] = rdat[i];
        end
        req_valid = rst_req ? '0 : pend;
        tx_busy   = force_busy || (cyc >= u_start && cyc < u_end);
    endtask

    task automatic sample();
        logic [NR-1:0] e_ready;
        int w;
        @(negedge clk);
        if (reset) begin
            m_active    = 0;
            m_busy_seen = 0;
            m_issue_at  = -1;
            m_idle_at   = -1;
            m_err_at    = -1;
            m_last      = NR - 1;
            m_gid       = 0;
            m_byte      = '0;
            u_start     = -1;
            u_end       = -1;
        end else begin
            w       = -1;
            e_ready = '0;
            if (!m_active && !tx_busy) begin
                for (int k = 1; k <= NR; k++) begin
                    if (w < 0 && req_valid[(m_last + k) % NR]) w = (m_last + k) % NR;
                end
            end
            if (w >= 0) e_ready[w] = 1'b1;
            check_eq("ready", req_ready, e_ready);
            check_eq("data_valid", tx_data_valid, cyc == m_issue_at);
            check_eq("p_data", tx_p_data, m_byte);
            check_eq("grant_id", grant_id, m_gid);
            check_eq("sched_busy", sched_busy, m_active);
            check_eq("err_no_start", err_no_start, cyc == m_err_at);

            if (w >= 0) begin
                m_active    = 1;
                m_busy_seen = 0;
                m_issue_at  = cyc + 1;
                m_idle_at   = -1;
                m_last      = w;
                m_gid       = w;
                m_byte      = req_data[w*FW +: FW];
            end else if (m_active) begin
                if (m_idle_at < 0 && cyc > m_issue_at) begin
                    if (!m_busy_seen) begin
                        if (tx_busy) m_busy_seen = 1;
                        else if (cyc == m_issue_at + TO) begin
                            m_err_at  = cyc + 1;
                            m_idle_at = cyc + 1 + GAP;
                        end
                    end else if (!tx_busy) begin
                        m_idle_at = cyc + 1 + GAP;
                    end
                end
                if (m_idle_at >= 0 && cyc + 1 >= m_idle_at) m_active = 0;
            end

            if (tx_data_valid) begin
                strobe_cyc.push_back(cyc);
                strobe_id.push_back(int'(grant_id));
                strobe_dat.push_back(int'(tx_p_data));
                if (!u_nostart) begin
                    u_start = cyc + u_delay;
                    u_end   = u_start + u_len;
                end
            end
            if (err_no_start) err_cyc.push_back(cyc);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i] && req_valid[i] && !rearm[i]) pend[i] = 1'b0;
            end
        end
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
    endtask

    task automatic tick();
        drive();
        sample();
    endtask

    task automatic do_reset();
        rst_req = 1;
        tick();
        rst_req = 0;
    endtask

    task automatic clear_logs();
        strobe_cyc.delete();
        strobe_id.delete();
        strobe_dat.delete();
        err_cyc.delete();
    endtask

    task automatic wait_ready(input string tag, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget && at < 0; n++) begin
            tick();
            if (req_ready != '0) at = cyc;
        end
        check_eq({tag, "_seen"}, 32'(at >= 0), 1);
    endtask

    task automatic run_until_strobes(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && strobe_cyc.size() < n; k++) tick();
        check_eq({tag, "_strobes"}, strobe_cyc.size(), n);
    endtask

    task automatic run_until_idle(input int budget);
        for (int k = 0; k < budget && (sched_busy || tx_busy || pend != '0); k++) tick();
        check_eq("idle_reached", sched_busy, 0);
    endtask

    initial begin
        int rdy;
        reset     = 1'b1;
        rst_req   = 1;
        pend      = '0;
        rearm     = '0;
        req_valid = '0;
        req_data  = '0;
        tx_busy   = 1'b0;
        for (int i = 0; i < NR; i++) rdat[i] = '0;

        repeat (2) tick();
        rst_req = 0;
        tick();
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_dv", tx_data_valid, 0);
        check_eq("rst_pdata", tx_p_data, 0);
        check_eq("rst_gid", grant_id, 0);
        check_eq("rst_sbusy", sched_busy, 0);
        check_eq("rst_err", err_no_start, 0);

        // single request, then a second one to measure the gap
        u_delay = 1;
        u_len   = 11;
        rdat[0] = 8'hA5;
        pend    = 4'b0001;
        tick();
        check_eq("single_ready", req_ready, 4'b0001);
        tick();
        check_eq("single_dv", tx_data_valid, 1);
        check_eq("single_pdata", tx_p_data, 8'hA5);
        check_eq("single_gid", grant_id, 0);
        tick();
        check_eq("single_dv_once", tx_data_valid, 0);
        rdat[1] = 8'h3C;
        pend    = 4'b0010;
        wait_ready("gap", 60, rdy);
        check_eq("gap_spacing", rdy - fall_cyc, 1 + GAP);
        run_until_idle(200);

        // fairness with all requesters continuously valid
        do_reset();
        clear_logs();
        for (int i = 0; i < NR; i++) rdat[i] = FW'(8'h10 + i);
        pend  = 4'b1111;
        rearm = 4'b1111;
        run_until_strobes("fair", 5, 200);
        rearm = '0;
        pend  = '0;
        if (strobe_cyc.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check_eq($sformatf("fair_id%0d", k), strobe_id[k], k % NR);
                check_eq($sformatf("fair_data%0d", k), strobe_dat[k], 8'h10 + (k % NR));
            end
        end
        run_until_idle(200);

        // UART never goes busy
        do_reset();
        clear_logs();
        u_nostart = 1;
        pend      = 4'b0110;
        run_until_strobes("nostart", 2, 100);
        for (int k = 0; k < 20 && err_cyc.size() < 2; k++) tick();
        check_eq("nostart_errs", err_cyc.size(), 2);
        if (strobe_cyc.size() >= 2 && err_cyc.size() >= 2) begin
            check_eq("nostart_err_lat", err_cyc[0] - strobe_cyc[0], 1 + TO);
            check_eq("nostart_err_lat2", err_cyc[1] - strobe_cyc[1], 1 + TO);
            check_eq("nostart_id0", strobe_id[0], 1);
            check_eq("nostart_id1", strobe_id[1], 2);
            check_eq("nostart_spacing", strobe_cyc[1] - strobe_cyc[0], TO + GAP + 2);
        end
        u_nostart = 0;
        run_until_idle(200);

        // tx_busy held high while idle
        force_busy = 1;
        pend       = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("busyidle_noready", req_ready, 0);
        end
        force_busy = 0;
        tick();
        check_eq("busyidle_grant", req_ready, 4'b0001);
        run_until_idle(200);

        // reset while the UART is mid-frame
        clear_logs();
        u_len = 20;
        pend  = 4'b0001;
        run_until_strobes("mid", 1, 20);
        repeat (4) tick();
        check_eq("mid_in_frame", sched_busy, 1);
        pend    = '0;
        rst_req = 1;
        tick();
        rst_req = 0;
        pend    = 4'b0101;
        tick();
        check_eq("mid_dv", tx_data_valid, 0);
        check_eq("mid_pdata", tx_p_data, 0);
        check_eq("mid_gid", grant_id, 0);
        check_eq("mid_sbusy", sched_busy, 0);
        check_eq("mid_err", err_no_start, 0);
        check_eq("mid_ready", req_ready, 4'b0001);
        u_len = 11;
        run_until_idle(300);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b1;
                else if (pend[i] && $urandom_range(0, 40) == 0) pend[i] = 1'b0;
            end
            u_delay    = int'($urandom_range(1, 6));
            u_len      = int'($urandom_range(1, 12));
            u_nostart  = ($urandom_range(0, 9) == 0);
            force_busy = ($urandom_range(0, 30) == 0);
            rst_req    = ($urandom_range(0, 300) == 0);
            tick();
        end
        rst_req    = 0;
        force_busy = 0;
        u_nostart  = 0;
        pend       = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
